fproc_meas_responder: RTL and testbench

- Responder end of the fproc request/response interface issued by each distributed processor core.
- Captures per-channel measurement results from readout and answers core fproc requests (enable + id) with data + ready.
- One independent responder FSM per core. Per-core/per-channel "fresh" tracking lets every core consume each measurement once, with no cross-core arbitration.

---
 rtl/fproc_meas_responder.sv | 126 ++++++++++++
 tb/tb_fproc_meas_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fproc_meas_responder.sv
// Answers per-core fproc requests with measurement results captured from readout.
// Every core has its own responder FSM and its own fresh flags, so no arbitration is needed.
module fproc_meas_responder #(
   parameter int                  N_CORES    = 2,
   parameter int                  N_MEAS     = 8,
   parameter int                  DATA_WIDTH = 32,
   parameter int                  ID_WIDTH   = 8,
   parameter logic [ID_WIDTH-1:0] ID_ALL     = {ID_WIDTH{1'b1}},
   parameter int                  TIMEOUT    = 1024
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [N_CORES*ID_WIDTH-1:0]    fproc_id,
   input  logic [N_CORES-1:0]             fproc_enable,
   output logic [N_CORES*DATA_WIDTH-1:0]  fproc_data,
   output logic [N_CORES-1:0]             fproc_ready,
   input  logic [N_MEAS-1:0]              meas_valid,
   input  logic [N_MEAS-1:0]              meas_bit
);

   localparam int IDX_W = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [ID_WIDTH-1:0] N_MEAS_ID = ID_WIDTH'(N_MEAS);
   localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                              state [N_CORES];
   logic [N_CORES-1:0][IDX_W-1:0]       wait_ch;
   logic [N_CORES-1:0][CNT_W-1:0]       wait_cnt;
   logic [N_MEAS-1:0]                   latest;
   logic [N_CORES-1:0][N_MEAS-1:0]      fresh;
   logic [N_CORES-1:0][N_MEAS-1:0]      consume;
   logic [N_CORES-1:0][ID_WIDTH-1:0]    req_id;
   logic [N_CORES-1:0][IDX_W-1:0]       req_ch;
   logic [N_CORES-1:0]                  req_in_range;

   assign req_id = fproc_id;

   function automatic logic [DATA_WIDTH-1:0] zext(input logic b);
      return {{(DATA_WIDTH-1){1'b0}}, b};
   endfunction

   // A channel is consumed by a core when that core takes its result this cycle,
   // either from the fresh flag or straight from a same-cycle measurement.
   always_comb begin
      for (int c = 0; c < N_CORES; c++) begin
         req_ch[c]       = req_id[c][IDX_W-1:0];
         req_in_range[c] = (req_id[c] < N_MEAS_ID);
         consume[c]      = '0;
         if (state[c] == IDLE && fproc_enable[c] && req_in_range[c]) begin
            if (fresh[c][req_ch[c]] || meas_valid[req_ch[c]])
               consume[c][req_ch[c]] = 1'b1;
         end else if (state[c] == WAIT && meas_valid[wait_ch[c]]) begin
            consume[c][wait_ch[c]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         latest      <= '0;
         fresh       <= '0;
         wait_ch     <= '0;
         wait_cnt    <= '0;
         fproc_ready <= '0;
         fproc_data  <= '0;
         for (int c = 0; c < N_CORES; c++)
            state[c] <= IDLE;
      end else begin
         latest <= (latest & ~meas_valid) | (meas_bit & meas_valid);
         for (int c = 0; c < N_CORES; c++) begin
            fresh[c]       <= (fresh[c] | meas_valid) & ~consume[c];
            fproc_ready[c] <= 1'b0;
            case (state[c])
               IDLE: begin
                  if (fproc_enable[c]) begin
                     if (req_id[c] == ID_ALL) begin
                        fproc_data[c*DATA_WIDTH +: DATA_WIDTH] <= DATA_WIDTH'(latest);
                        fproc_ready[c] <= 1'b1;
                        state[c]       <= RESP;
                     end else if (!req_in_range[c]) begin
                        fproc_data[c*DATA_WIDTH +: DATA_WIDTH] <= '0;
                        fproc_ready[c] <= 1'b1;
                        state[c]       <= RESP;
                     end else if (fresh[c][req_ch[c]]) begin
                        fproc_data[c*DATA_WIDTH +: DATA_WIDTH] <= zext(latest[req_ch[c]]);
                        fproc_ready[c] <= 1'b1;
                        state[c]       <= RESP;
                     end else if (meas_valid[req_ch[c]]) begin
                        fproc_data[c*DATA_WIDTH +: DATA_WIDTH] <= zext(meas_bit[req_ch[c]]);
                        fproc_ready[c] <= 1'b1;
                        state[c]       <= RESP;
                     end else begin
                        wait_ch[c]  <= req_ch[c];
                        wait_cnt[c] <= '0;
                        state[c]    <= WAIT;
                     end
                  end
               end
               WAIT: begin
                  if (meas_valid[wait_ch[c]]) begin
                     fproc_data[c*DATA_WIDTH +: DATA_WIDTH] <= zext(meas_bit[wait_ch[c]]);
                     fproc_ready[c] <= 1'b1;
                     state[c]       <= RESP;
                  end else if (TIMEOUT != 0 && wait_cnt[c] == CNT_LAST) begin
                     // Timed-out requests answer with all ones so the core never stalls forever.
                     fproc_data[c*DATA_WIDTH +: DATA_WIDTH] <= '1;
                     fproc_ready[c] <= 1'b1;
                     state[c]       <= RESP;
                  end else begin
                     wait_cnt[c] <= wait_cnt[c] + 1'b1;
                  end
               end
               RESP:    state[c] <= IDLE;
               default: state[c] <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fproc_meas_responder.sv
// Bench for fproc_meas_responder: directed vector table, hand-written corner
// sequences, then randomized traffic checked against a transaction-level model.
module tb_fproc_meas_responder;

   localparam int NC = 2;
   localparam int NM = 8;
   localparam int DW = 32;
   localparam int IW = 8;
   localparam int TO = 16;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [NC*IW-1:0]   fproc_id = '0;
   logic [NC-1:0]      fproc_enable = '0;
   logic [NC*DW-1:0]   fproc_data;
   logic [NC-1:0]      fproc_ready;
   logic [NM-1:0]      meas_valid = '0;
   logic [NM-1:0]      meas_bit = '0;

   always #5 clk = ~clk;

   fproc_meas_responder #(
      .N_CORES(NC), .N_MEAS(NM), .DATA_WIDTH(DW), .ID_WIDTH(IW),
      .ID_ALL(8'hFF), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset), .fproc_id(fproc_id), .fproc_enable(fproc_enable),
      .fproc_data(fproc_data), .fproc_ready(fproc_ready),
      .meas_valid(meas_valid), .meas_bit(meas_bit)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: per-core request bookkeeping with absolute cycle deadlines.
   logic [7:0]  m_latest;
   bit          m_fresh [NC][NM];
   bit          m_wait [NC];
   bit          m_resp [NC];
   int          m_wid [NC];
   int          m_deadline [NC];
   logic [31:0] m_data [NC];
   logic [1:0]  m_rdy;
   int          ncyc;

   task automatic model_reset();
      m_latest = '0;
      m_rdy = '0;
      ncyc = 0;
      for (int c = 0; c < NC; c++) begin
         m_wait[c] = 0;
         m_resp[c] = 0;
         m_wid[c] = 0;
         m_deadline[c] = 0;
         m_data[c] = '0;
         for (int ch = 0; ch < NM; ch++) m_fresh[c][ch] = 0;
      end
   endtask

   task automatic model_resp(input int c, input logic [31:0] v);
      m_rdy[c] = 1'b1;
      m_data[c] = v;
      m_resp[c] = 1;
      m_wait[c] = 0;
   endtask

   task automatic model_step(input logic [1:0] en, input logic [7:0] i0, input logic [7:0] i1,
                             input logic [7:0] mv, input logic [7:0] mb);
      bit cons [NC][NM];
      int id;
      for (int c = 0; c < NC; c++)
         for (int ch = 0; ch < NM; ch++) cons[c][ch] = 0;
      for (int c = 0; c < NC; c++) begin
         id = (c == 0) ? int'(i0) : int'(i1);
         m_rdy[c] = 1'b0;
         if (m_resp[c]) begin
            m_resp[c] = 0;
         end else if (m_wait[c]) begin
            if (mv[m_wid[c]]) begin
               model_resp(c, {31'b0, mb[m_wid[c]]});
               cons[c][m_wid[c]] = 1;
            end else if (ncyc == m_deadline[c]) begin
               model_resp(c, 32'hFFFF_FFFF);
            end
         end else if (en[c]) begin
            if (id == 255) model_resp(c, {24'b0, m_latest});
            else if (id >= NM) model_resp(c, 32'h0);
            else if (m_fresh[c][id]) begin
               model_resp(c, {31'b0, m_latest[id]});
               cons[c][id] = 1;
            end else if (mv[id]) begin
               model_resp(c, {31'b0, mb[id]});
               cons[c][id] = 1;
            end else begin
               m_wait[c] = 1;
               m_wid[c] = id;
               m_deadline[c] = ncyc + TO;
            end
         end
      end
      for (int ch = 0; ch < NM; ch++) begin
         if (mv[ch]) m_latest[ch] = mb[ch];
         for (int c = 0; c < NC; c++) begin
            if (cons[c][ch]) m_fresh[c][ch] = 0;
            else if (mv[ch]) m_fresh[c][ch] = 1;
         end
      end
      ncyc++;
   endtask

   task automatic step(input logic [1:0] en, input logic [7:0] i0, input logic [7:0] i1,
                       input logic [7:0] mv, input logic [7:0] mb);
      fproc_enable = en;
      fproc_id = {i1, i0};
      meas_valid = mv;
      meas_bit = mb;
      model_step(en, i0, i1, mv, mb);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]  en;
      logic [7:0]  i0, i1, mv, mb;
      logic [1:0]  rdy;
      logic [31:0] d0, d1;
   } vec_t;

   vec_t tbl [$];

   task automatic add(input logic [1:0] en, input logic [7:0] i0, input logic [7:0] i1,
                      input logic [7:0] mv, input logic [7:0] mb,
                      input logic [1:0] rdy, input logic [31:0] d0, input logic [31:0] d1);
      vec_t v;
      v.en = en; v.i0 = i0; v.i1 = i1; v.mv = mv; v.mb = mb;
      v.rdy = rdy; v.d0 = d0; v.d1 = d1;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] en;
      logic [7:0] ids [NC];
      logic [7:0] mv, mb;
      int         r, dens;

      model_reset();
      // Table: en, id0, id1, meas_valid, meas_bit, ready, data0, data1
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h0, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h08, 8'h08, 2'd0, 32'h0, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h0, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h0, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h0, 32'h0);
      add(2'd1, 8'h03, 8'h00, 8'h00, 8'h00, 2'd1, 32'h1, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h1, 32'h0);
      add(2'd1, 8'h03, 8'h00, 8'h00, 8'h00, 2'd0, 32'h1, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h1, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h08, 8'h00, 2'd1, 32'h0, 32'h0);
      add(2'd2, 8'h00, 8'h02, 8'h00, 8'h00, 2'd0, 32'h0, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h0, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h0, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h04, 8'h00, 2'd2, 32'h0, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h0, 32'h0);
      add(2'd3, 8'h02, 8'h02, 8'h00, 8'h00, 2'd1, 32'h0, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h04, 8'h04, 2'd2, 32'h0, 32'h1);
      add(2'd0, 8'h00, 8'h00, 8'hFF, 8'hA5, 2'd0, 32'h0, 32'h1);
      add(2'd1, 8'hFF, 8'h00, 8'h00, 8'h00, 2'd1, 32'hA5, 32'h1);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'hA5, 32'h1);
      add(2'd1, 8'h09, 8'h00, 8'h00, 8'h00, 2'd1, 32'h0, 32'h1);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h0, 32'h1);
      add(2'd3, 8'h04, 8'h04, 8'h00, 8'h00, 2'd3, 32'h0, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h0, 32'h0);
      add(2'd1, 8'h04, 8'h00, 8'h10, 8'h10, 2'd1, 32'h1, 32'h0);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h1, 32'h0);
      add(2'd3, 8'h04, 8'h04, 8'h00, 8'h00, 2'd2, 32'h1, 32'h1);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h1, 32'h1);
      add(2'd0, 8'h00, 8'h00, 8'h10, 8'h00, 2'd1, 32'h0, 32'h1);
      add(2'd0, 8'h00, 8'h00, 8'h01, 8'h00, 2'd0, 32'h0, 32'h1);
      add(2'd0, 8'h00, 8'h00, 8'h01, 8'h01, 2'd0, 32'h0, 32'h1);
      add(2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 2'd1, 32'h1, 32'h1);
      add(2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 32'h1, 32'h1);

      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", {30'b0, fproc_ready}, 32'h0);
      chk("reset_data0", fproc_data[31:0], 32'h0);
      chk("reset_data1", fproc_data[63:32], 32'h0);
      reset = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].en, tbl[i].i0, tbl[i].i1, tbl[i].mv, tbl[i].mb);
         chk($sformatf("vec%0d_ready", i), {30'b0, fproc_ready}, {30'b0, tbl[i].rdy});
         chk($sformatf("vec%0d_data0", i), fproc_data[31:0], tbl[i].d0);
         chk($sformatf("vec%0d_data1", i), fproc_data[63:32], tbl[i].d1);
      end

      // Timeout on channel 0 with extra enables hammering during WAIT.
      step(2'd1, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("to_enter_ready", {30'b0, fproc_ready}, 32'h0);
      for (int k = 1; k < TO; k++) begin
         step(2'd1, 8'h00, 8'h00, 8'h00, 8'h00);
         chk($sformatf("to_wait%0d_ready", k), {30'b0, fproc_ready}, 32'h0);
      end
      step(2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("to_fire_ready", {30'b0, fproc_ready}, 32'h1);
      chk("to_fire_data0", fproc_data[31:0], 32'hFFFF_FFFF);
      step(2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("to_after_ready", {30'b0, fproc_ready}, 32'h0);
      chk("to_after_data0", fproc_data[31:0], 32'hFFFF_FFFF);

      // Reset while core0 waits.
      step(2'd1, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("rw_enter_ready", {30'b0, fproc_ready}, 32'h0);
      repeat (3) step(2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
      reset = 1'b0;
      #1;
      chk("rw_async_data0", fproc_data[31:0], 32'h0);
      chk("rw_async_data1", fproc_data[63:32], 32'h0);
      model_reset();
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk("rw_hold_ready", {30'b0, fproc_ready}, 32'h0);
      end
      reset = 1'b1;
      step(2'd0, 8'h00, 8'h00, 8'h01, 8'h01);
      chk("rw_stale_wait_ready", {30'b0, fproc_ready}, 32'h0);
      step(2'd1, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("rw_req_ready", {30'b0, fproc_ready}, 32'h1);
      chk("rw_req_data0", fproc_data[31:0], 32'h1);
      step(2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
      step(2'd1, 8'hFF, 8'h00, 8'h00, 8'h00);
      chk("rw_all_ready", {30'b0, fproc_ready}, 32'h1);
      chk("rw_all_data0", fproc_data[31:0], 32'h1);
      step(2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
      chk("rw_idle_ready", {30'b0, fproc_ready}, 32'h0);

      // Randomized traffic: dense measurements first, then sparse ones so timeouts occur.
      for (int i = 0; i < 1500; i++) begin
         dens = (i < 750) ? 8 : 64;
         en = 2'($urandom_range(0, 3) & $urandom_range(0, 3));
         for (int c = 0; c < NC; c++) begin
            r = $urandom_range(0, 9);
            if (r < 8) ids[c] = 8'(r);
            else if (r == 8) ids[c] = 8'hFF;
            else ids[c] = 8'($urandom_range(8, 15));
         end
         mv = '0;
         for (int ch = 0; ch < NM; ch++) mv[ch] = ($urandom_range(0, dens - 1) == 0);
         mb = 8'($urandom);
         step(en, ids[0], ids[1], mv, mb);
         chk("rnd_ready", {30'b0, fproc_ready}, {30'b0, m_rdy});
         chk("rnd_data0", fproc_data[31:0], m_data[0]);
         chk("rnd_data1", fproc_data[63:32], m_data[1]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
